// File: rtl/rv32i_data_mem_responder.sv
// Data-side memory responder for the multicycle RV32I core: one outstanding
// request, byte-lane aligned access to a local word array, fixed-latency response.
module rv32i_data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    MEM_NOOP   = 2'd0,
    LOAD       = 2'd1,
    STORE      = 2'd2,
    OP_ILLEGAL = 2'd3
  } memory_op_t;

  typedef enum logic [1:0] {
    BYTE         = 2'd0,
    HALF_WORD    = 2'd1,
    WORD         = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } memory_size_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  logic [31:0]  r_mem [DEPTH_WORDS];
  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_rsp_valid;
  logic         r_rsp_err;
  logic [31:0]  r_rsp_rdata;

  memory_op_t   w_op;
  memory_size_t w_size;
  logic         w_accept;
  logic         w_misalign;
  logic         w_oor;
  logic         w_err;
  logic         w_we;
  logic [AW-1:0] w_idx;
  logic [31:0]  w_word;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [31:0]  w_rdata;
  logic [3:0]   w_be;
  logic [31:0]  w_wlanes;

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

  always_comb begin
    w_op       = memory_op_t'(req_op);
    w_size     = memory_size_t'(req_size);
    w_misalign = ((w_size == HALF_WORD) && req_addr[0]) ||
                 ((w_size == WORD) && (req_addr[1:0] != 2'b00));
    w_oor      = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
    // NOOP ignores address and size, so only the op code itself can fault it.
    w_err      = (w_op == OP_ILLEGAL) ||
                 (((w_op == LOAD) || (w_op == STORE)) &&
                  ((w_size == SIZE_ILLEGAL) || w_misalign || w_oor));
    w_idx      = req_addr[AW+1:2];
    w_word     = r_mem[w_idx];
    w_byte     = w_word[{req_addr[1:0], 3'b000} +: 8];
    w_half     = w_word[{req_addr[1], 4'b0000} +: 16];

    w_rdata = '0;
    if ((w_op == LOAD) && !w_err) begin
      case (w_size)
        BYTE:      w_rdata = {{24{!req_unsigned && w_byte[7]}}, w_byte};
        HALF_WORD: w_rdata = {{16{!req_unsigned && w_half[15]}}, w_half};
        default:   w_rdata = w_word;
      endcase
    end

    w_be     = '0;
    w_wlanes = req_wdata;
    case (w_size)
      BYTE: begin
        w_be     = 4'b0001 << req_addr[1:0];
        w_wlanes = {4{req_wdata[7:0]}};
      end
      HALF_WORD: begin
        w_be     = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{req_wdata[15:0]}};
      end
      WORD:    w_be = 4'b1111;
      default: w_be = '0;
    endcase
    w_we = w_accept && (w_op == STORE) && !w_err;
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= w_rdata;
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_data_mem_responder.sv
// Self-checking bench: two responders (latency 4 and 1) share one request
// stream and are compared against a byte-array reference model.
module tb_rv32i_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_mem [DEPTH*4];

  always #5 clk = ~clk;

  rv32i_data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_op(req_op), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  rv32i_data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_op(req_op), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, loads assembled arithmetically.
  function automatic void model(input logic [1:0] op, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wd,
                                output logic [31:0] d, output logic e);
    int unsigned n;
    longint v;
    d = '0;
    e = 1'b0;
    if (op == 2'd0) return;
    if (op == 2'd3 || sz == 2'd3) begin e = 1'b1; return; end
    n = 1 << sz;
    if ((addr % n) != 0 || (addr / 4) >= DEPTH) begin e = 1'b1; return; end
    if (op == 2'd2) begin
      for (int unsigned k = 0; k < n; k++) m_mem[addr + k] = 8'(wd >> (8 * k));
      return;
    end
    v = 0;
    for (int unsigned k = 0; k < n; k++) v += longint'(m_mem[addr + k]) << (8 * k);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    d = 32'(v);
  endfunction

  task automatic wait_ready(input string nm);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_req_ready && b_req_ready) begin ok = 1; break; end
    end
    if (!ok) chk({nm, "_ready_timeout"}, 32'(a_req_ready && b_req_ready), 32'd1);
  endtask

  task automatic txn(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e, input string nm);
    int first_a = -1, first_b = -1, cnt_a = 0, cnt_b = 0;
    logic [31:0] d_a = '0, d_b = '0;
    logic e_a = 1'b0, e_b = 1'b0;
    wait_ready(nm);
    req_op = op; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 1'b0;
        chk({nm, "_busy_ready"}, {30'd0, a_req_ready, b_req_ready}, 32'd0);
      end
      if (a_rsp_valid) begin
        if (first_a < 0) begin first_a = k; d_a = a_rsp_rdata; e_a = a_rsp_err; end
        cnt_a++;
      end
      if (b_rsp_valid) begin
        if (first_b < 0) begin first_b = k; d_b = b_rsp_rdata; e_b = b_rsp_err; end
        cnt_b++;
      end
    end
    chk({nm, "_a_lat"}, 32'(first_a), 32'(LAT_A - 1));
    chk({nm, "_b_lat"}, 32'(first_b), 32'(LAT_B - 1));
    chk({nm, "_a_vcnt"}, 32'(cnt_a), 32'd1);
    chk({nm, "_b_vcnt"}, 32'(cnt_b), 32'd1);
    chk({nm, "_a_rdata"}, d_a, exp_d);
    chk({nm, "_b_rdata"}, d_b, exp_d);
    chk({nm, "_a_err"}, 32'(e_a), 32'(exp_e));
    chk({nm, "_b_err"}, 32'(e_b), 32'(exp_e));
  endtask

  initial begin
    vec_t tbl[$];
    logic [31:0] md, wd, addr;
    logic me;
    logic [1:0] op, sz;
    int r, vcnt;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {30'd0, a_req_ready, b_req_ready}, 32'd0);
    chk("rst_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    chk("rst_err", {30'd0, a_rsp_err, b_rsp_err}, 32'd0);
    chk("rst_a_rdata", a_rsp_rdata, 32'd0);
    chk("rst_b_rdata", b_rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {30'd0, a_req_ready, b_req_ready}, 32'd3);

    // Give every word a defined value
    for (int w = 0; w < DEPTH; w++) begin
      wd = $urandom;
      model(2'd2, 2'd2, 1'b0, 32'(w * 4), wd, md, me);
      txn(2'd2, 2'd2, 1'b0, 32'(w * 4), wd, md, me, $sformatf("init%0d", w));
    end

    tbl.push_back('{2'd2, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{2'd1, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{2'd2, 2'd2, 1'b0, 32'h20, 32'h80F17F01, 32'h0,        1'b0});
    tbl.push_back('{2'd1, 2'd0, 1'b0, 32'h22, 32'h0,        32'hFFFFFFF1, 1'b0});
    tbl.push_back('{2'd1, 2'd0, 1'b1, 32'h22, 32'h0,        32'h000000F1, 1'b0});
    tbl.push_back('{2'd1, 2'd1, 1'b0, 32'h22, 32'h0,        32'hFFFF80F1, 1'b0});
    tbl.push_back('{2'd1, 2'd0, 1'b0, 32'h20, 32'h0,        32'h00000001, 1'b0});
    tbl.push_back('{2'd1, 2'd1, 1'b1, 32'h20, 32'h0,        32'h00007F01, 1'b0});
    tbl.push_back('{2'd1, 2'd1, 1'b1, 32'h22, 32'h0,        32'h000080F1, 1'b0});
    tbl.push_back('{2'd2, 2'd2, 1'b0, 32'h30, 32'h11223344, 32'h0,        1'b0});
    tbl.push_back('{2'd2, 2'd0, 1'b0, 32'h31, 32'hFFFFFFAA, 32'h0,        1'b0});
    tbl.push_back('{2'd2, 2'd1, 1'b0, 32'h32, 32'h1234BEEF, 32'h0,        1'b0});
    tbl.push_back('{2'd1, 2'd2, 1'b0, 32'h30, 32'h0,        32'hBEEFAA44, 1'b0});
    tbl.push_back('{2'd1, 2'd2, 1'b0, 32'h32, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{2'd2, 2'd1, 1'b0, 32'h31, 32'h0000FFFF, 32'h0,        1'b1});
    tbl.push_back('{2'd1, 2'd2, 1'b0, 32'(DEPTH*4), 32'h0,  32'h0,        1'b1});
    tbl.push_back('{2'd3, 2'd2, 1'b0, 32'h30, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{2'd1, 2'd2, 1'b0, 32'h30, 32'h0,        32'hBEEFAA44, 1'b0});
    tbl.push_back('{2'd1, 2'd0, 1'b0, 32'h33, 32'h0,        32'hFFFFFFBE, 1'b0});
    tbl.push_back('{2'd0, 2'd3, 1'b0, 32'h3,  32'h0,        32'h0,        1'b0});
    tbl.push_back('{2'd1, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{2'd2, 2'd2, 1'b0, 32'h0,  32'h0BADF00D, 32'h0,        1'b0});
    tbl.push_back('{2'd2, 2'd2, 1'b0, 32'(DEPTH*4), 32'hFFFFFFFF, 32'h0,  1'b1});
    tbl.push_back('{2'd1, 2'd2, 1'b0, 32'h0,  32'h0,        32'h0BADF00D, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].op, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, md, me);
      txn(tbl[i].op, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
          tbl[i].exp_d, tbl[i].exp_e, $sformatf("vec%0d", i));
    end

    // Backpressure: response held while a competing request is ignored
    wait_ready("bp");
    req_op = 2'd1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    req_wdata = '0; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_op = 2'd2; req_wdata = 32'h55555555;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_rsp_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("bp_a_arrive", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", i), {30'd0, a_rsp_valid, b_rsp_valid}, 32'd3);
      chk($sformatf("bp_ready%0d", i), {30'd0, a_req_ready, b_req_ready}, 32'd0);
      chk($sformatf("bp_a_data%0d", i), a_rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp_b_data%0d", i), b_rsp_rdata, 32'hDEADBEEF);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {30'd0, a_req_ready, b_req_ready}, 32'd3);
    chk("bp_release_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    txn(2'd1, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "bp_reload");

    // Reset with a store in flight (A busy, B waiting in response)
    wait_ready("rstmid");
    req_op = 2'd2; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40;
    req_wdata = 32'h12345678; req_valid = 1'b1; rsp_ready = 1'b0;
    model(2'd2, 2'd2, 1'b0, 32'h40, 32'h12345678, md, me);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    chk("rstmid_ready", {30'd0, a_req_ready, b_req_ready}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_rsp_valid || b_rsp_valid) vcnt++;
    end
    chk("rstmid_no_rsp", 32'(vcnt), 32'd0);
    txn(2'd1, 2'd2, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0, "rstmid_load");

    // Randomized traffic against the model
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 19);
      op = (r < 9) ? 2'd1 : (r < 17) ? 2'd2 : (r < 19) ? 2'd0 : 2'd3;
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      addr = ($urandom_range(0, 99) < 8) ? $urandom : 32'($urandom_range(0, DEPTH*4-1));
      wd = $urandom;
      me = 1'b0;
      r = $urandom_range(0, 1);
      model(op, sz, r[0], addr, wd, md, me);
      txn(op, sz, r[0], addr, wd, md, me, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
